// File: rtl/mem_if_pkg.sv
// Shared types and byte-lane strobe constants for the load/store bus adapter.
package mem_if_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage

// File: rtl/mem_load_align.sv
// Right-justifies and zero-extends the lane(s) of a bus read word selected by size and offset.
module mem_load_align
    import mem_if_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] rdata_o
);

    always_comb begin
        rdata_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                case (off_i)
                    2'd0:    rdata_o = {24'b0, rdata_i[7:0]};
                    2'd1:    rdata_o = {24'b0, rdata_i[15:8]};
                    2'd2:    rdata_o = {24'b0, rdata_i[23:16]};
                    default: rdata_o = {24'b0, rdata_i[31:24]};
                endcase
            end
            SZ_HALF: rdata_o = off_i[1] ? {16'b0, rdata_i[31:16]} : {16'b0, rdata_i[15:0]};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_iface.sv
// Core-to-bus load/store adapter: word-aligned address, lane strobes, replicated store data.
// MEM_IF_MISALIGN_CHECK_EN adds misalignment rejection and the sticky mem_err_o flag.
module mem_iface
    import mem_if_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [1:0]  mem_size_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        mem_valid_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
`ifdef MEM_IF_MISALIGN_CHECK_EN
    output logic        mem_err_o,
`endif
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    logic [1:0] off;
    logic [3:0] strb;
    logic       misaligned;
    logic       req_ok;

    assign off        = mem_addr_i[1:0];
    assign mem_addr_o = {mem_addr_i[31:2], 2'b00};

    always_comb begin
        strb        = STRB_WORD;
        mem_wdata_o = mem_wdata_i;
        case (mem_size_i)
            SZ_BYTE: begin
                strb        = STRB_BYTE << off;
                mem_wdata_o = {4{mem_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                strb        = STRB_HALF << {off[1], 1'b0};
                mem_wdata_o = {2{mem_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MEM_IF_MISALIGN_CHECK_EN
    assign misaligned = ((mem_size_i == SZ_HALF) && off[0]) || (mem_size_i[1] && (off != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned request never reaches the bus but completes immediately toward the core.
    assign req_ok      = rst_n_i & mem_req_i & ~misaligned;
    assign mem_valid_o = req_ok;
    assign mem_write_o = req_ok & mem_we_i;
    assign mem_wstrb_o = mem_write_o ? strb : STRB_NONE;
    assign mem_ready_o = rst_n_i & mem_req_i & (mem_ready_i | misaligned);

    mem_load_align u_load_align (
        .rdata_i (mem_rdata_i),
        .size_i  (mem_size_i),
        .off_i   (off),
        .rdata_o (mem_rdata_o)
    );

`ifdef MEM_IF_MISALIGN_CHECK_EN
    logic err_d;
    logic err_q;

    always_comb begin
        err_d = err_q;
        if (mem_req_i && misaligned) begin
            err_d = 1'b1;
        end else if (mem_req_i && mem_ready_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem_err_o = err_q;
`else
    logic unused_clk;
    assign unused_clk = clk_i;
`endif

endmodule

// File: tb/tb_mem_iface.sv
// Bench for mem_iface: directed cases plus randomized requests against an arithmetic reference model.
module tb_mem_iface;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [1:0]  mem_size_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_ready_o;
    logic        mem_valid_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_err_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;

`ifdef MEM_IF_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
    assign mem_err_o = 1'b0;
`endif

    mem_iface dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_size_i  (mem_size_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_ready_o (mem_ready_o),
        .mem_valid_o (mem_valid_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
`ifdef MEM_IF_MISALIGN_CHECK_EN
        .mem_err_o   (mem_err_o),
`endif
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: byte count and offset arithmetic straight from the access rules.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_mis(input logic [31:0] addr, input logic [1:0] sz);
        if (!CHK_EN) return 1'b0;
        return (addr % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] rd, input logic [31:0] addr,
                                                input logic [1:0] sz);
        int n;
        int base;
        logic [63:0] mask;
        n    = nbytes(sz);
        base = (addr % 4) / n * n;
        mask = (64'd1 << (8 * n)) - 1;
        return 32'((64'(rd) >> (8 * base)) & mask);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
        case (nbytes(sz))
            1:       return (wd % 256) * 32'h0101_0101;
            2:       return (wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] addr, input logic [1:0] sz);
        int n;
        int base;
        n    = nbytes(sz);
        base = (addr % 4) / n * n;
        return 4'(((1 << n) - 1) << base);
    endfunction

    // Drives one cycle of stimulus just after a rising edge, checks at the falling edge,
    // then checks the error flag just after the next rising edge.
    task automatic run(input string tag, input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz, input logic [31:0] rd,
                       input bit rdy);
        bit mis;
        bit go;
        mem_req_i   = req;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_wdata_i = wd;
        mem_size_i  = sz;
        mem_rdata_i = rd;
        mem_ready_i = rdy;
        mis = model_mis(addr, sz);
        go  = req && !mis;
        @(negedge clk_i);
        check({tag, ".valid"}, mem_valid_o, go);
        check({tag, ".write"}, mem_write_o, go && we);
        check({tag, ".ready"}, mem_ready_o, req && (rdy || mis));
        check({tag, ".addr"},  mem_addr_o, addr - (addr % 4));
        check({tag, ".wdata"}, mem_wdata_o, model_wdata(wd, sz));
        check({tag, ".wstrb"}, mem_wstrb_o, (go && we) ? model_strb(addr, sz) : 4'b0000);
        check({tag, ".rdata"}, mem_rdata_o, model_rdata(rd, addr, sz));
        @(posedge clk_i);
        if (req && mis) exp_err = 1'b1;
        else if (req && rdy) exp_err = 1'b0;
        #1;
        check({tag, ".err"}, mem_err_o, exp_err);
    endtask

    initial begin
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b1;
        mem_size_i = 2'b10;
        mem_ready_i = 1'b1;
        #12;
        check("rst.valid", mem_valid_o, 1'b0);
        check("rst.write", mem_write_o, 1'b0);
        check("rst.ready", mem_ready_o, 1'b0);
        check("rst.wstrb", mem_wstrb_o, 4'b0000);
        check("rst.err",   mem_err_o,   1'b0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        run("ldb",  1, 0, 32'h1, 32'h0,         2'b00, 32'hAABBCCDD, 1);
        run("ldh",  1, 0, 32'h2, 32'h0,         2'b01, 32'hAABBCCDD, 1);
        run("ldw",  1, 0, 32'h4, 32'h0,         2'b10, 32'hAABBCCDD, 1);
        run("ld11", 1, 0, 32'h8, 32'h0,         2'b11, 32'h12345678, 1);
        run("stw",  1, 1, 32'h0, 32'h11223344, 2'b10, 32'h0,        1);
        run("stb",  1, 1, 32'h3, 32'h00000055, 2'b00, 32'h0,        1);
        run("sth",  1, 1, 32'h2, 32'h0000BEEF, 2'b01, 32'h0,        1);
        run("idle", 0, 1, 32'h2, 32'h0000BEEF, 2'b01, 32'h0,        1);

        for (int i = 0; i < 3; i++) begin
            run("stall", 1, 1, 32'h104, 32'hCAFEF00D, 2'b10, 32'h5A5A5A5A, 0);
        end
        run("stall_done", 1, 1, 32'h104, 32'hCAFEF00D, 2'b10, 32'h5A5A5A5A, 1);

        if (CHK_EN) begin
            run("mis_h",  1, 1, 32'h1, 32'h0000BEEF, 2'b01, 32'h0, 1);
            run("mis_hold", 0, 0, 32'h0, 32'h0,      2'b10, 32'h0, 1);
            run("mis_w",  1, 0, 32'h6, 32'h0,        2'b10, 32'hAABBCCDD, 0);
            run("mis_clr", 1, 0, 32'h4, 32'h0,       2'b10, 32'hAABBCCDD, 1);
            run("mis_set", 1, 0, 32'h3, 32'h0,       2'b11, 32'hAABBCCDD, 0);
        end

        // Reset dropped in the middle of a stalled store.
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_addr_i  = 32'h20;
        mem_size_i  = 2'b10;
        mem_ready_i = 1'b0;
        #2;
        check("mid.pre_valid", mem_valid_o, 1'b1);
        rst_n_i = 1'b0;
        #1;
        exp_err = 1'b0;
        check("mid.valid", mem_valid_o, 1'b0);
        check("mid.ready", mem_ready_o, 1'b0);
        check("mid.write", mem_write_o, 1'b0);
        check("mid.wstrb", mem_wstrb_o, 4'b0000);
        check("mid.err",   mem_err_o,   1'b0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 300; i++) begin
            run("rnd", ($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom,
                $urandom, 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_iface.md
# mem_iface

Load/store unit bus adapter between the core's execute/memory stage and the 32-bit system memory bus. It converts byte/halfword/word requests into word-aligned bus transactions with byte-lane strobes and replicated write data. It also right-justifies returned read data into the core-facing read bus. The datapath is combinational with zero added latency. The only flop is the optional misalignment-error flag.

## Interface
- No parameters (data and address width fixed at 32).
- clk_i  in  1  system clock
- rst_n_i  in  1  reset; asynchronous, active-low
- mem_req_i  in  1  core request valid; held high until mem_ready_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  byte address
- mem_wdata_i  in  32  store data, right-justified
- mem_size_i  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- mem_rdata_o  out  32  load data, right-justified, zero-extended (sign extension done by core)
- mem_ready_o  out  1  request complete this cycle
- mem_valid_o  out  1  bus request valid
- mem_write_o  out  1  bus write
- mem_addr_o  out  32  word-aligned address {mem_addr_i[31:2],2'b00}
- mem_wdata_o  out  32  lane-replicated store data
- mem_wstrb_o  out  4  byte-lane strobes; 0000 on loads
- mem_rdata_i  in  32  bus read data (full word)
- mem_ready_i  in  1  bus completion
- mem_err_o  out  1  misalignment error (present only with MEM_IF_MISALIGN_CHECK_EN)

## Operation
- Offset off = mem_addr_i[1:0].
- mem_valid_o = mem_req_i. mem_write_o = mem_req_i & mem_we_i.
- mem_ready_o = mem_req_i & mem_ready_i.
- Store strobes:
  - byte: 0001 << off
  - half: 0011 << {off[1],0}
  - word: 1111
- Store data:
  - byte: wdata[7:0] replicated ×4
  - half: wdata[15:0] replicated ×2
  - word: as is
- Load data:
  - byte: {24'b0, lane off of mem_rdata_i}
  - half: {16'b0, half selected by off[1]}
  - word: mem_rdata_i
- Without the check macro:
  - halfword ignores off[0].
  - word ignores off.
- mem_rdata_o is valid only while mem_ready_o is high. Otherwise it still follows the formula; consumers must not sample it.

## Timing
- All bus and core outputs are combinational from inputs. A request completes in the same cycle mem_ready_i is high.
- mem_ready_i low: outputs track the held request; the core must keep all inputs stable.
- Back-to-back requests each take one cycle when mem_ready_i stays high.
- While rst_n_i is low, these outputs are forced to 0: mem_valid_o, mem_write_o, mem_ready_o, mem_wstrb_o, mem_err_o. Address, wdata and rdata outputs may follow inputs.
- Reset asserted mid-transaction aborts it immediately; there is no replay.

## Configuration
- MEM_IF_MISALIGN_CHECK_EN defined:
  - A halfword with off[0]=1, or a word with off≠0, is misaligned.
  - For a misaligned request, mem_valid_o=0, mem_write_o=0, mem_wstrb_o=0000.
  - mem_ready_o=1 in the request cycle.
  - mem_err_o is a flop set on the clock edge ending that cycle; it holds 1 until the next completed aligned request or reset.
- Undefined: no check, no mem_err_o port; alignment bits are silently ignored as above.

## Structure
- Package mem_if_pkg holds:
  - mem_size_e enum (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10)
  - strobe constants
- One sub-module, mem_load_align: mem_rdata_i, size, off in; right-justified load data out.
- Strobe and wdata replication stay inline in the top.

## Test plan
- Load byte, bus rdata 0xAABBCCDD, mem_ready_i=1, addr 0x1, size 00 -> mem_rdata_o 0x000000CC, mem_ready_o 1, mem_addr_o 0x0, mem_wstrb_o 0000, mem_write_o 0.
- Load half, addr 0x2, size 01 -> mem_rdata_o 0x0000AABB; word load at addr 0x4 -> 0xAABBCCDD, mem_addr_o 0x4.
- Store word, addr 0x0, wdata 0x11223344, size 10 -> mem_write_o 1, mem_wstrb_o 1111, mem_wdata_o 0x11223344.
- Store byte, addr 0x3, wdata 0x00000055 -> mem_wstrb_o 1000, mem_wdata_o 0x55555555.
- Store half, addr 0x2, wdata 0xBEEF -> mem_wstrb_o 1100, mem_wdata_o 0xBEEFBEEF.
- Stall and reset:
  - mem_ready_i low 3 cycles -> mem_ready_o 0, outputs stable.
  - rst_n_i low mid-request -> mem_valid_o and mem_ready_o 0 immediately.
  - With the macro: half at addr 0x1 -> mem_valid_o 0, mem_ready_o 1, mem_err_o 1 after the clock edge.
